// File: rtl/vga_sprite_compositor_pkg.sv
// vga_sprite_compositor_pkg: shared video geometry defaults, pixel type and colour field positions
package vga_sprite_compositor_pkg;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int COLOR_W      = 24;
    localparam int R_LSB        = 0;
    localparam int G_LSB        = 8;
    localparam int B_LSB        = 16;
    typedef logic [COLOR_W-1:0] pixel_t;
endpackage

// File: rtl/vga_sprite_compositor_if.sv
// vga_sprite_compositor_if: video stream into and out of the sprite compositor
interface vga_sprite_compositor_if;
    import vga_sprite_compositor_pkg::*;
    logic       iBLANK_n, iHS, iVS;
    pixel_t     bg_bgr;
    logic       oBLANK_n, oHS, oVS;
    logic [7:0] b_data, g_data, r_data;
    modport master (output iBLANK_n, iHS, iVS, bg_bgr,
                    input  oBLANK_n, oHS, oVS, b_data, g_data, r_data);
    modport slave  (input  iBLANK_n, iHS, iVS, bg_bgr,
                    output oBLANK_n, oHS, oVS, b_data, g_data, r_data);
endinterface

// File: rtl/vga_sprite_compositor_hit.sv
// vga_sprite_compositor_hit: per-sprite frame-latched shadow registers and bounds compare
module vga_sprite_compositor_hit
    import vga_sprite_compositor_pkg::*;
#(
    parameter int XW    = 10,
    parameter int YW    = 9,
    parameter int SPR_W = 32,
    parameter int SPR_H = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [XW-1:0] in_x,
    input  logic [YW-1:0] in_y,
    input  logic          in_en,
    input  pixel_t        in_bgr,
    output logic          hit,
    output pixel_t        bgr
);
    localparam logic [XW:0] W_EXT = SPR_W;
    localparam logic [YW:0] H_EXT = SPR_H;
    logic [XW-1:0] sx;
    logic [YW-1:0] sy;
    logic          en;
    always_ff @(posedge clk)
        if (!rst_n) begin
            sx  <= '0;
            sy  <= '0;
            en  <= 1'b0;
            bgr <= '0;
        end else if (load) begin
            sx  <= in_x;
            sy  <= in_y;
            en  <= in_en;
            bgr <= in_bgr;
        end
    // right/bottom edges carry an extra bit so sprites near the border clip instead of wrapping
    assign hit = en & (x >= sx) & ({1'b0, x} < {1'b0, sx} + W_EXT)
                    & (y >= sy) & ({1'b0, y} < {1'b0, sy} + H_EXT);
endmodule

// File: rtl/vga_sprite_compositor.sv
// vga_sprite_compositor: priority overlay of fixed-size solid sprites on the background video
// with frame-latched positions, per-frame collision flags and a fixed 2-cycle pipeline.
module vga_sprite_compositor
    import vga_sprite_compositor_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 32,
    parameter int XW          = 10,
    parameter int YW          = 9
) (
    input  logic                           iVGA_CLK,
    input  logic                           iRST_n,
    vga_sprite_compositor_if.slave         vid,
    input  logic [NUM_SPRITES*XW-1:0]      spr_x,
    input  logic [NUM_SPRITES*YW-1:0]      spr_y,
    input  logic [NUM_SPRITES-1:0]         spr_en,
    input  logic [NUM_SPRITES*COLOR_W-1:0] spr_bgr,
    output logic [NUM_SPRITES-1:0]         collide,
    output logic                           frame_done
);
    logic [XW-1:0]          x;
    logic [YW-1:0]          y;
    logic                   vs_q, locked, fs, blank_q, hs_q, vs_d;
    logic [NUM_SPRITES-1:0] hit, hit_q, sticky;
    pixel_t                 spr_col [NUM_SPRITES];
    pixel_t                 bg_q, pix;
    assign fs = vs_q & ~vid.iVS;
    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_spr
        vga_sprite_compositor_hit #(.XW(XW), .YW(YW), .SPR_W(SPR_W), .SPR_H(SPR_H)) u_hit (
            .clk(iVGA_CLK), .rst_n(iRST_n), .load(fs), .x(x), .y(y),
            .in_x(spr_x[i*XW +: XW]), .in_y(spr_y[i*YW +: YW]), .in_en(spr_en[i]),
            .in_bgr(spr_bgr[i*COLOR_W +: COLOR_W]), .hit(hit[i]), .bgr(spr_col[i])
        );
    end
    // scan from lowest priority upward so sprite 0 overrides everything
    always_comb begin
        pix = bg_q;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) pix = hit_q[i] ? spr_col[i] : pix;
    end
    always_ff @(posedge iVGA_CLK)
        if (!iRST_n) begin
            {x, y, vs_q, locked, blank_q, hs_q, vs_d, bg_q, hit_q, sticky} <= '0;
            {vid.oBLANK_n, vid.oHS, vid.oVS, vid.b_data, vid.g_data, vid.r_data} <= '0;
            collide    <= '0;
            frame_done <= 1'b0;
        end else begin
            vs_q          <= vid.iVS;
            blank_q       <= vid.iBLANK_n;
            hs_q          <= vid.iHS;
            vs_d          <= vid.iVS;
            bg_q          <= vid.bg_bgr;
            hit_q         <= hit;
            vid.oBLANK_n  <= blank_q;
            vid.oHS       <= hs_q;
            vid.oVS       <= vs_d;
            vid.b_data    <= locked ? pix[B_LSB +: 8] : 8'h00;
            vid.g_data    <= locked ? pix[G_LSB +: 8] : 8'h00;
            vid.r_data    <= locked ? pix[R_LSB +: 8] : 8'h00;
            frame_done    <= fs;
            if (fs) begin
                x       <= '0;
                y       <= '0;
                locked  <= 1'b1;
                collide <= sticky;
                sticky  <= '0;
            end else if (vid.iBLANK_n) begin
                x <= (x == XW'(H_ACTIVE - 1)) ? '0 : x + XW'(1);
                if (x == XW'(H_ACTIVE - 1) && y != YW'(V_ACTIVE - 1)) y <= y + YW'(1);
                // counters are meaningless until the first frame start, so skip accumulation
                if (locked && $countones(hit) > 1) sticky <= sticky | hit;
            end
        end
endmodule
